// File: rtl/seg7_to_hex_reader_if.sv
// Bundle of the control inputs and decoded results of the 7-segment reader.
// The bench or wrapper drives through master; the reader itself uses slave.
interface seg7_to_hex_reader_if;
    logic       ena;
    logic       clear;
    logic [6:0] seg_in;
    logic [3:0] hex_out;
    logic       valid;
    logic       err;
    logic [7:0] digits;
    logic [7:0] err_count;

    modport master (
        output ena, clear, seg_in,
        input  hex_out, valid, err, digits, err_count
    );

    modport slave (
        input  ena, clear, seg_in,
        output hex_out, valid, err, digits, err_count
    );
endinterface

// File: rtl/seg7_to_hex_reader.sv
// Debounces a 7-segment drive pattern and decodes it back to a hex nibble with a 2-digit history.
// Define SEG7_READER_ERRCNT_EN to build the 8-bit saturating illegal-pattern counter.
//
// state    | meaning
// IDLE     | candidate is blank
// SETTLING | counting identical samples of a non-blank candidate
// LOCKED   | current candidate already reported
module seg7_to_hex_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    seg7_to_hex_reader_if.slave bus
);
    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETTLING = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] s1_q, s1_d;
    logic [6:0] cand_q, cand_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] hex_q, hex_d;
    logic [7:0] digits_q, digits_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;
    logic       accept;
    logic       glyph_ok;
    logic [3:0] glyph_val;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            s1_q     <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            hex_q    <= '0;
            digits_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_q     <= s1_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            hex_q    <= hex_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    // Clear outranks ena; the sync stage itself is not cleared, it only keeps sampling.
    always_comb begin
        state_d = state_q;
        s1_d    = s1_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        if (bus.clear) begin
            state_d = ST_IDLE;
            cand_d  = '0;
            cnt_d   = '0;
            if (bus.ena) s1_d = bus.seg_in;
        end else if (bus.ena) begin
            s1_d = bus.seg_in;
            if (s1_q != cand_q) begin
                cand_d  = s1_q;
                cnt_d   = 8'd1;
                state_d = (s1_q == 7'd0) ? ST_IDLE : ST_SETTLING;
            end else if (state_q == ST_SETTLING) begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOCKED;
                    accept  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        end
    end

    always_comb begin
        glyph_ok  = 1'b1;
        glyph_val = 4'h0;
        case (cand_q)
            7'h3F: glyph_val = 4'h0;
            7'h06: glyph_val = 4'h1;
            7'h5B: glyph_val = 4'h2;
            7'h4F: glyph_val = 4'h3;
            7'h66: glyph_val = 4'h4;
            7'h6D: glyph_val = 4'h5;
            7'h7D: glyph_val = 4'h6;
            7'h07: glyph_val = 4'h7;
            7'h7F: glyph_val = 4'h8;
            7'h6F: glyph_val = 4'h9;
            7'h77: glyph_val = 4'hA;
            7'h7C: glyph_val = 4'hB;
            7'h39: glyph_val = 4'hC;
            7'h5E: glyph_val = 4'hD;
            7'h79: glyph_val = 4'hE;
            7'h71: glyph_val = 4'hF;
            default: glyph_ok = 1'b0;
        endcase
    end

    always_comb begin
        valid_d  = accept & glyph_ok;
        err_d    = accept & ~glyph_ok;
        hex_d    = hex_q;
        digits_d = digits_q;
        if (bus.clear) begin
            hex_d    = '0;
            digits_d = '0;
        end else if (valid_d) begin
            hex_d    = glyph_val;
            digits_d = {digits_q[3:0], glyph_val};
        end
    end

`ifdef SEG7_READER_ERRCNT_EN
    logic [7:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (bus.clear) begin
            err_count_d = '0;
        end else if (err_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) err_count_q <= '0;
        else        err_count_q <= err_count_d;
    end

    assign bus.err_count = err_count_q;
`else
    assign bus.err_count = 8'h00;
`endif

    // Pulses are masked while frozen so a pulse cannot linger across an ena-low stretch.
    assign bus.valid   = valid_q & bus.ena;
    assign bus.err     = err_q & bus.ena;
    assign bus.hex_out = hex_q;
    assign bus.digits  = digits_q;
endmodule
